// File: rtl/riscv_muldiv.sv
// riscv_muldiv -- iterative RV32 M-extension execute unit (MUL/MULH/MULHSU/
// MULHU/DIV/DIVU/REM/REMU), the multi-cycle partner of the EX-stage ALU.
//
// Operation: an op is accepted in IDLE, runs XLEN radix-2 steps in CALC
// (shift-add multiply or restoring divide on operand magnitudes), has its sign
// fixed and its result selected in FIX, and is presented in DONE until the
// consumer takes it. Divide-by-zero and signed-overflow divides are resolved
// at accept and go straight to DONE.
//
// Optional build macro:
//   RISCV_MULDIV_FAST_MUL_EN  multiplies use a registered signed 33x33
//                             product (one CALC cycle) instead of the
//                             iterative datapath; divides are unchanged.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous abort of any in-flight op (highest priority)
//   req_valid   request present          req_ready  high only in IDLE
//   req_op      funct3 of the M op       req_a/b    rs1/rs2 operands
//   rsp_valid   result valid (DONE)      rsp_ready  consumer takes result
//   rsp_result  result, holds last value; 0 until the first completion
//   busy        high whenever not IDLE
module riscv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic                neg_q;      // result needs two's-complement correction
    logic [XLEN-1:0]     opb;        // mul: |a| (addend); div: |b| (divisor)
    logic [2*XLEN-1:0]   acc;        // mul: {hi, multiplier}; div: {rem, dividend/quotient}

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_sign_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Request decode (only meaningful in the accept cycle).
    logic            req_div, req_a_sgn, req_b_sgn, sa, sb;
    logic            div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] special_res;

    always_comb begin
        req_div   = req_op[2];
        req_a_sgn = (req_op == 3'b001) || (req_op == 3'b010) ||
                    (req_op == 3'b100) || (req_op == 3'b110);
        req_b_sgn = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
        sa        = req_a_sgn && req_a[XLEN-1];
        sb        = req_b_sgn && req_b[XLEN-1];
        div_zero  = req_div && (req_b == '0);
        div_ovf   = req_div && !req_op[0] && (req_b == '1) &&
                    (req_a == {1'b1, {(XLEN-1){1'b0}}});
        special   = div_zero || div_ovf;
        // Zero divisor: quotient all ones, remainder = a.
        // Overflow: quotient = a (most negative), remainder 0.
        if (div_zero)
            special_res = req_op[1] ? req_a : '1;
        else
            special_res = req_op[1] ? '0 : req_a;
        accept    = (state == IDLE) && req_valid && !flush;
    end

    // One radix-2 step of whichever datapath the latched op selects.
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] step_acc;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fast_prod;
`endif

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb};
        // The difference is below the divisor, so XLEN bits hold it exactly.
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opb) : div_shift[XLEN-1:0];
        step_acc  = op_q[2] ? {div_rem, acc[XLEN-2:0], div_ge}
                            : {mul_sum, acc[XLEN-1:1]};
`ifdef RISCV_MULDIV_FAST_MUL_EN
        // Raw operands, sign-extended per op; low 2*XLEN bits of the signed
        // product are the full result, so no sign fix is needed afterwards.
        fa = {{XLEN{((op_q == 3'b001) || (op_q == 3'b010)) && opb[XLEN-1]}}, opb};
        fb = {{XLEN{(op_q == 3'b001) && acc[XLEN-1]}}, acc[XLEN-1:0]};
        fast_prod = fa * fb;
        if (!op_q[2])
            step_acc = fast_prod;
`endif
    end

    // Sign correction and result selection for FIX.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s = fix_sign_wide(acc, neg_q);
        case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = fix_sign(acc[XLEN-1:0], neg_q);
            default:                fix_res = fix_sign(acc[2*XLEN-1:XLEN], neg_q);
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = IDLE;
        else begin
            case (state)
                IDLE: if (req_valid) state_nx = special ? DONE : CALC;
                CALC: if (cnt == LAST) state_nx = FIX;
                FIX:  state_nx = DONE;
                DONE: if (rsp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == DONE);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            opb        <= '0;
            acc        <= '0;
            rsp_result <= '0;
        end else if (accept) begin
            op_q  <= req_op;
            cnt   <= '0;
            neg_q <= (req_div && req_op[1]) ? sa : (sa ^ sb);
            if (req_div) begin
                opb <= mag(req_b, req_b_sgn);
                acc <= {{XLEN{1'b0}}, mag(req_a, req_a_sgn)};
            end else begin
                opb <= mag(req_a, req_a_sgn);
                acc <= {{XLEN{1'b0}}, mag(req_b, req_b_sgn)};
            end
`ifdef RISCV_MULDIV_FAST_MUL_EN
            // Keep raw operands and do the single product step next cycle.
            if (!req_div) begin
                opb   <= req_a;
                acc   <= {{XLEN{1'b0}}, req_b};
                neg_q <= 1'b0;
                cnt   <= LAST;
            end
`endif
            if (special)
                rsp_result <= special_res;
        end else if (!flush && state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= step_acc;
        end else if (!flush && state == FIX) begin
            rsp_result <= fix_res;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv -- self-checking bench for riscv_muldiv: directed cases,
// backpressure, flush, asynchronous reset and randomized ops, all checked
// against a plain-arithmetic reference model.
module tb_riscv_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics with 64-bit / 32-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Clock edges after the accepting edge until rsp_valid is seen high
    // (0 = result is already valid straight after the accepting edge).
    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 0)) return 0;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef RISCV_MULDIV_FAST_MUL_EN
        if (!op[2]) return 2;
`endif
        return 33;
    endfunction

    // Called at posedge+1 with the unit idle; returns at posedge+1 with it idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] exp_res, held;
        int          exp_lat, lat;
        logic        hs_bad, bp_bad;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        check_val({tag, ".idle_rdy"}, 32'(req_ready), 32'd1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Operands must be ignored after accept.
        req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 0; hs_bad = 1'b0;
        while (!rsp_valid && lat < 200) begin
            if (req_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
        check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".res"}, rsp_result, exp_res);
        check_val({tag, ".busy"}, 32'(hs_bad), 32'd0);
        held = rsp_result; bp_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_result !== held || req_ready !== 1'b0) bp_bad = 1'b1;
        end
        check_val({tag, ".hold"}, 32'(bp_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val({tag, ".ret"}, {30'b0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        logic        seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          mode;

        // Reset held across two edges.
        @(posedge clk); @(posedge clk); #1;
        check_val("rst.flags", {29'b0, req_ready, busy, rsp_valid}, 32'b100);
        check_val("rst.result", rsp_result, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0, "mulhu_min");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
        run_op(3'd5, 32'd100, 32'd7, 0, "divu");
        run_op(3'd7, 32'd100, 32'd7, 0, "remu");
        run_op(3'd4, 32'd5, 32'd0, 0, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, 2, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

        // Flush on the 10th CALC cycle of a DIV.
        req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check_val("flush.pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush.idle", {29'b0, busy, req_ready, rsp_valid}, 32'b010);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check_val("flush.no_rsp", 32'(seen), 32'd0);

        // flush wins over a simultaneous request.
        req_op = 3'd0; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check_val("flush.no_accept", 32'(busy), 32'd0);

        run_op(3'd5, 32'd100, 32'd7, 0, "divu_after_flush");

        // Asynchronous reset in the middle of CALC, away from any edge.
        req_op = 3'd0; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check_val("arst.flags", {29'b0, req_ready, busy, rsp_valid}, 32'b100);
        check_val("arst.result", rsp_result, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd12, 32'd11, 0, "mul_after_rst");

        // Randomized ops with corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = $urandom_range(1, 15);
            else if (mode == 3) a = $urandom_range(0, 255);
            run_op(op, a, b, $urandom_range(0, 3), $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
